// File: rtl/odometer_meas_seq_stacked.sv
// Measurement sequencer for the stacked odometer: stress / settle / window / done
// sequencing with registered, glitch-free power-enable and counter-control outputs.
module odometer_meas_seq_stacked #(
  parameter int WIN_W      = 10,
  parameter int SETTLE_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STRESS_EN,
  input  logic             MEAS_REQ,
  input  logic [WIN_W-1:0] WIN_LEN,
  output logic             START,
  output logic             MEAS_STRESS,
  output logic             MEAS_DONE,
  output logic             CNT_CLR,
  output logic             CNT_EN,
  output logic             MEAS_VALID,
  output logic             BUSY,
  input  logic             VDD,
  input  logic             VSS
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRESS  = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    DONE1   = 3'd4,
    DONE2   = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [WIN_W-1:0]   win_cnt_r, win_nxt_s, win_load_s;
  logic [SET_W-1:0]   settle_cnt_r, settle_nxt_s;
  logic               start_r, meas_stress_r, meas_done_r, cnt_clr_r;
  logic               cnt_en_r, meas_valid_r, busy_r;
  logic               start_s, meas_stress_s, meas_done_s, cnt_clr_s;
  logic               cnt_en_s, meas_valid_s, busy_s;
  logic               unused_supply_s;

  assign unused_supply_s = VDD ^ VSS;

  // A zero-length window still gives one counting cycle.
  assign win_load_s = (WIN_LEN == {WIN_W{1'b0}}) ? WIN_W'(1) : WIN_LEN;

  // Next-state, counter and output decode; outputs follow the state being entered.
  always_comb begin
    state_nxt_s   = state_r;
    win_nxt_s     = win_cnt_r;
    settle_nxt_s  = settle_cnt_r;
    start_s       = 1'b0;
    meas_stress_s = 1'b0;
    meas_done_s   = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_en_s      = 1'b0;
    meas_valid_s  = 1'b0;
    busy_s        = 1'b0;

    case (state_r)
      IDLE, STRESS: begin
        if (MEAS_REQ) begin
          state_nxt_s  = SETTLE;
          settle_nxt_s = SET_W'(SETTLE_CYC - 1);
          win_nxt_s    = win_load_s;
        end else if (STRESS_EN) begin
          state_nxt_s = STRESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_r == {SET_W{1'b0}}) begin
          state_nxt_s = MEASURE;
        end else begin
          settle_nxt_s = settle_cnt_r - SET_W'(1);
        end
      end
      MEASURE: begin
        if (win_cnt_r <= WIN_W'(1)) begin
          state_nxt_s = DONE1;
        end else begin
          win_nxt_s = win_cnt_r - WIN_W'(1);
        end
      end
      DONE1: begin
        state_nxt_s = DONE2;
      end
      DONE2: begin
        if (STRESS_EN) begin
          state_nxt_s = STRESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    case (state_nxt_s)
      STRESS: begin
        start_s = 1'b1;
      end
      SETTLE: begin
        // Make-before-break: keep stress power on for the first settle cycle.
        start_s       = (state_r == STRESS);
        meas_stress_s = 1'b1;
        cnt_clr_s     = 1'b1;
        busy_s        = 1'b1;
      end
      MEASURE: begin
        meas_stress_s = 1'b1;
        cnt_en_s      = 1'b1;
        busy_s        = 1'b1;
      end
      DONE1: begin
        meas_stress_s = 1'b1;
        meas_done_s   = 1'b1;
        meas_valid_s  = 1'b1;
        busy_s        = 1'b1;
      end
      DONE2: begin
        start_s       = STRESS_EN;
        meas_stress_s = 1'b1;
        meas_done_s   = 1'b1;
        busy_s        = 1'b1;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r        <= IDLE;
      win_cnt_r      <= {WIN_W{1'b0}};
      settle_cnt_r   <= {SET_W{1'b0}};
      start_r        <= 1'b0;
      meas_stress_r  <= 1'b0;
      meas_done_r    <= 1'b0;
      cnt_clr_r      <= 1'b0;
      cnt_en_r       <= 1'b0;
      meas_valid_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      win_cnt_r      <= win_nxt_s;
      settle_cnt_r   <= settle_nxt_s;
      start_r        <= start_s;
      meas_stress_r  <= meas_stress_s;
      meas_done_r    <= meas_done_s;
      cnt_clr_r      <= cnt_clr_s;
      cnt_en_r       <= cnt_en_s;
      meas_valid_r   <= meas_valid_s;
      busy_r         <= busy_s;
    end
  end

  assign START       = start_r;
  assign MEAS_STRESS = meas_stress_r;
  assign MEAS_DONE   = meas_done_r;
  assign CNT_CLR     = cnt_clr_r;
  assign CNT_EN      = cnt_en_r;
  assign MEAS_VALID  = meas_valid_r;
  assign BUSY        = busy_r;

endmodule
